pcg_rng_arbiter: RTL and testbench

- Controller and arbiter for the team's 128-bit PCG generator (LCG plus permutation).
- The generator advances every clock and has no enable, so this block owns its seed and reset, and sequences seeding and warm-up.
- Once the generator is running, it hands each generated word to exactly one of N requesters through round-robin grants.
- Sits between the generator instance and the consumers of random words.

---
 rtl/pcg_rng_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pcg_rng_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pcg_rng_arbiter.sv
// Seeding/warm-up sequencer and round-robin word distributor for the 128-bit PCG generator.
// Optional macro PCG_ARB_AUTORESEED_EN: reseed from the granted word every RESEED_INTERVAL grants.
module pcg_rng_arbiter #(
    parameter int          N               = 4,
    parameter logic [127:0] DEFAULT_SEED   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
    parameter int          HOLD_CYCLES     = 2,
    parameter int          WARMUP          = 4,
    parameter int          RESEED_INTERVAL = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [127:0]   seed_in,
    input  logic           seed_load,
    output logic [127:0]   gen_seed,
    output logic           gen_rst,
    input  logic [127:0]   gen_data,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [127:0]   rnd_out,
    output logic           rnd_valid,
    output logic           ready
);

    localparam int PW   = (N > 1) ? $clog2(N) : 1;
    localparam int CMAX = (HOLD_CYCLES > WARMUP) ? HOLD_CYCLES : WARMUP;
    localparam int CW   = $clog2(CMAX + 1);

    if (N < 1 || N > 16) begin : g_bad_n
        $error("pcg_rng_arbiter: N must be 1..16");
    end
    if (HOLD_CYCLES < 1 || WARMUP < 1 || RESEED_INTERVAL < 1) begin : g_bad_cnt
        $error("pcg_rng_arbiter: HOLD_CYCLES, WARMUP and RESEED_INTERVAL must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [127:0]    seed_q, seed_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [127:0]    rnd_q, rnd_d;
    logic            vld_q, vld_d;
    logic [PW-1:0]   sel;
    logic            grant;

`ifdef PCG_ARB_AUTORESEED_EN
    localparam int GW = (RESEED_INTERVAL > 1) ? $clog2(RESEED_INTERVAL) : 1;
    logic [GW-1:0]   gcnt_q, gcnt_d;
`endif

    // First requester at or after the pointer, wrapping modulo N.
    function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] res;
        logic [PW-1:0] k;
        logic          found;
        res   = p;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = PW'((int'(p) + i) % N);
            if (!found && r[k]) begin
                res   = k;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        seed_d  = seed_q;
        gnt_d   = '0;
        vld_d   = 1'b0;
        rnd_d   = rnd_q;
`ifdef PCG_ARB_AUTORESEED_EN
        gcnt_d  = gcnt_q;
`endif
        sel   = rr_pick(req, ptr_q);
        grant = (state_q == ST_RUN) && (|req) && !seed_load;

        case (state_q)
            ST_SEED: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WARMUP: begin
                if (cnt_q == CW'(WARMUP - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_SEED;
                cnt_d   = '0;
            end
        endcase

        if (grant) begin
            gnt_d[sel] = 1'b1;
            vld_d      = 1'b1;
            rnd_d      = gen_data;
            ptr_d      = (int'(sel) == N - 1) ? '0 : sel + PW'(1);
`ifdef PCG_ARB_AUTORESEED_EN
            // The interval-completing grant still delivers its word, then folds it into the seed.
            if (gcnt_q == GW'(RESEED_INTERVAL - 1)) begin
                seed_d  = seed_q ^ gen_data;
                state_d = ST_SEED;
                cnt_d   = '0;
                gcnt_d  = '0;
            end else begin
                gcnt_d = gcnt_q + GW'(1);
            end
`endif
        end

        if (seed_load) begin
            seed_d  = seed_in;
            state_d = ST_SEED;
            cnt_d   = '0;
`ifdef PCG_ARB_AUTORESEED_EN
            gcnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            seed_q  <= DEFAULT_SEED;
            gnt_q   <= '0;
            rnd_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            seed_q  <= seed_d;
            gnt_q   <= gnt_d;
            rnd_q   <= rnd_d;
            vld_q   <= vld_d;
        end
    end

`ifdef PCG_ARB_AUTORESEED_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end
`endif

    assign gen_seed  = seed_q;
    assign gen_rst   = (state_q == ST_SEED);
    assign ready     = (state_q == ST_RUN);
    assign gnt       = gnt_q;
    assign rnd_out   = rnd_q;
    assign rnd_valid = vld_q;

endmodule

// File: tb/tb_pcg_rng_arbiter.sv
// Scoreboard bench for pcg_rng_arbiter: stimulus queues expected grants, a negedge monitor checks them.
module tb_pcg_rng_arbiter;

    localparam int           N     = 4;
    localparam logic [127:0] DSEED = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   seed_in;
    logic           seed_load;
    logic [127:0]   gen_seed;
    logic           gen_rst;
    logic [127:0]   gen_data;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [127:0]   rnd_out;
    logic           rnd_valid;
    logic           ready;

    always #5 clk = ~clk;

    pcg_rng_arbiter #(
        .N(N), .DEFAULT_SEED(DSEED), .HOLD_CYCLES(2), .WARMUP(4), .RESEED_INTERVAL(3)
    ) dut (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_load(seed_load),
        .gen_seed(gen_seed), .gen_rst(gen_rst), .gen_data(gen_data), .req(req),
        .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .ready(ready)
    );

    typedef struct {
        int           edge_no;
        logic [N-1:0] g;
        logic [127:0] d;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            edge_cnt;
    int unsigned   tick = 0;
    logic [127:0]  last_d;

    // Rising edges since the last reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [127:0] pattern(input int unsigned k);
        return {32'hDEAD0000 ^ k, k * 32'd7 + 32'h11, ~k, k};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        tick++;
        gen_data = pattern(tick);
    endtask

    // Expect a grant at the coming edge carrying the word presented this cycle.
    task automatic push(input logic [N-1:0] g);
        q.push_back('{edge_cnt + 1, g, gen_data});
        last_d = gen_data;
    endtask

    // Seeding began at edge b: gen_rst high after edges b and b+1, ready after b+6.
    task automatic seq_check(input int b);
        for (int e = b + 1; e <= b + 6; e++) begin
            next_cycle();
            chk("gen_rst_seq", {127'b0, gen_rst}, {127'b0, (edge_cnt < b + 2)});
            chk("ready_seq", {127'b0, ready}, {127'b0, (edge_cnt >= b + 6)});
        end
    endtask

    always @(negedge clk) begin
        if (rnd_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant: got gnt=%b at edge %0d, required none", gnt, edge_cnt);
            end else begin
                mon_e = q.pop_front();
                chk("grant_edge", 128'(edge_cnt), 128'(mon_e.edge_no));
                chk("grant_onehot", {124'b0, gnt}, {124'b0, mon_e.g});
                chk("grant_data", rnd_out, mon_e.d);
            end
        end else begin
            chk("idle_gnt", {124'b0, gnt}, 128'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        seed_load = 1'b0;
        seed_in   = '0;
        req       = '0;
        gen_data  = pattern(0);
        last_d    = '0;
        #12;
        chk("rst_gen_rst", {127'b0, gen_rst}, 128'd1);
        chk("rst_ready", {127'b0, ready}, 128'd0);
        chk("rst_valid", {127'b0, rnd_valid}, 128'd0);
        chk("rst_gnt", {124'b0, gnt}, 128'd0);
        chk("rst_rnd_out", rnd_out, 128'd0);
        chk("rst_gen_seed", gen_seed, DSEED);

`ifdef PCG_ARB_AUTORESEED_EN
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0001;
        seq_check(0);
        push(4'b0001);
        next_cycle(); push(4'b0001);
        next_cycle(); push(4'b0001);
        next_cycle();
        chk("auto_seed", gen_seed, DSEED ^ last_d);
        chk("auto_gen_rst", {127'b0, gen_rst}, 128'd1);
        chk("auto_ready", {127'b0, ready}, 128'd0);
        seq_check(9);
        push(4'b0001);
        next_cycle();
        req = 4'b0000;
        next_cycle();
        next_cycle();
`else
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        seq_check(0);
        push(4'b0001);
        next_cycle(); push(4'b0010);
        next_cycle(); push(4'b0100);
        next_cycle(); push(4'b1000);
        next_cycle(); push(4'b0001);
        next_cycle();
        chk("run_ready", {127'b0, ready}, 128'd1);
        req = 4'b0101;
        push(4'b0100);
        next_cycle(); push(4'b0001);
        next_cycle(); push(4'b0100);
        next_cycle();
        req = 4'b0000;
        next_cycle();
        next_cycle();
        chk("idle_hold_data", rnd_out, last_d);
        chk("idle_valid", {127'b0, rnd_valid}, 128'd0);
        chk("pre_load_ready", {127'b0, ready}, 128'd1);

        seed_load = 1'b1;
        seed_in   = 128'h1;
        req       = 4'b1111;
        next_cycle();
        seed_load = 1'b0;
        seed_in   = '0;
        chk("load_gen_seed", gen_seed, 128'h1);
        chk("load_gen_rst", {127'b0, gen_rst}, 128'd1);
        chk("load_ready", {127'b0, ready}, 128'd0);
        seq_check(17);
        push(4'b1000);
        next_cycle(); push(4'b0001);
        next_cycle(); push(4'b0010);
        next_cycle();
        req = 4'b0000;

        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_gnt", {124'b0, gnt}, 128'd0);
        chk("async_valid", {127'b0, rnd_valid}, 128'd0);
        chk("async_ready", {127'b0, ready}, 128'd0);
        chk("async_gen_rst", {127'b0, gen_rst}, 128'd1);
        chk("async_gen_seed", gen_seed, DSEED);
        chk("async_rnd_out", rnd_out, 128'd0);

        #10;
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0001;
        seq_check(0);
        push(4'b0001);
        next_cycle(); push(4'b0001);
        next_cycle(); push(4'b0001);
        next_cycle(); push(4'b0001);
        next_cycle();
        req = 4'b0000;
        next_cycle();
        chk("no_autoreseed_ready", {127'b0, ready}, 128'd1);
        chk("no_autoreseed_seed", gen_seed, DSEED);
`endif
        next_cycle();
        chk("queue_drained", 128'(q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
